// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the CPU fetch port
// (I) and the load/store port (D). Data has priority. A run counter bounds how
// many D grants can pass a waiting fetch. Every memory access has a
// cycle-count timeout that completes it with err.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_DATA_RUN = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              CLK,
    input  logic              Reset,
    // fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    // load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    // status
    output logic              err,
    output logic              cpu_stall,
    // memory side
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MEM_I = 2'd1;
    localparam logic [1:0] S_MEM_D = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] RUN_LIM  = 4'(MAX_DATA_RUN);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    // One memory command as latched on the grant edge.
    typedef struct packed {
        logic              we;
        logic [2:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    logic [1:0] state;
    logic [3:0] run_cnt;
    logic [7:0] tmo_cnt;
    mem_cmd_t   cmd;
    mem_cmd_t   d_cmd;
    mem_cmd_t   i_cmd;
    logic       d_win;
    logic       tmo_hit;

    // Fetches are always word reads, whatever the D-side inputs hold.
    assign d_cmd   = {d_we, d_size, d_addr, d_wdata};
    assign i_cmd   = {1'b0, 3'b010, i_addr, {DATA_W{1'b0}}};
    assign d_win   = d_req & (~i_req | (run_cnt < RUN_LIM));
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    assign mem_we    = cmd.we;
    assign mem_size  = cmd.size;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;

    // Stall drops in the ack cycle so the pipeline advances exactly once.
    assign cpu_stall = (i_req & ~i_ack) | (d_req & ~d_ack);

    // Arbitration, access sequencing, timeout and response registers.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            run_cnt <= '0;
            tmo_cnt <= '0;
            cmd     <= '0;
            mem_req <= 1'b0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            err     <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (d_win) begin
                        state   <= S_MEM_D;
                        cmd     <= d_cmd;
                        mem_req <= 1'b1;
                        tmo_cnt <= '0;
                        // Only D grants that pass a waiting fetch count.
                        if (i_req) run_cnt <= (run_cnt == 4'hF) ? run_cnt : run_cnt + 4'd1;
                        else       run_cnt <= '0;
                    end else if (i_req) begin
                        state   <= S_MEM_I;
                        cmd     <= i_cmd;
                        mem_req <= 1'b1;
                        tmo_cnt <= '0;
                        run_cnt <= '0;
                    end
                end
                S_MEM_I, S_MEM_D: begin
                    // An ack on the final timeout cycle still counts as success.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= S_RESP;
                        if (state == S_MEM_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_rdata;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= cmd.we ? '0 : mem_rdata;
                        end
                    end else if (tmo_hit) begin
                        mem_req <= 1'b0;
                        state   <= S_RESP;
                        err     <= 1'b1;
                        if (state == S_MEM_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= '0;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven single-access vectors, hand-written
// multi-cycle sequences, and a randomized run against a timeline model of
// the arbiter's access rules.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXR = 4;
    localparam int TMO  = 16;

    logic          CLK = 1'b0;
    logic          Reset = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [2:0]    d_size = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          err;
    logic          cpu_stall;
    logic          mem_req;
    logic          mem_we;
    logic [2:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_DATA_RUN(MAXR), .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .Reset(Reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .err(err), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One isolated access: port requests, memory latency (0 = never acks),
    // and the outcome the rules dictate.
    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [2:0]  d_size;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        int          lat;
        logic [31:0] rd;
        logic        e_port;   // 1 = D granted
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [2:0]  e_size;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_cyc;    // cycles mem_req stays high
        logic        e_stall;  // cpu_stall in the ack cycle, reqs still held
    } vec_t;

    vec_t vt[7];

    // reference-model state for the randomized phase
    bit          m_busy;
    int          m_t, m_n, m_lat, m_run;
    bit          m_port, m_err;
    logic        m_we;
    logic [2:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rd;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1, 32'h00500093,
                  1'b0, 32'h100, 32'h0, 1'b0, 3'b010, 32'h00500093, 1'b0, 1, 1'b0};
        vt[1] = '{1'b1, 32'h104, 1'b1, 1'b1, 3'b010, 32'h2000, 32'hDEADBEEF, 1, 32'h11111111,
                  1'b1, 32'h2000, 32'hDEADBEEF, 1'b1, 3'b010, 32'h0, 1'b0, 1, 1'b1};
        vt[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 3'b100, 32'h3000, 32'hA5A5A5A5, 8, 32'h12345678,
                  1'b1, 32'h3000, 32'hA5A5A5A5, 1'b0, 3'b100, 32'h12345678, 1'b0, 8, 1'b0};
        vt[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 0, 32'h0,
                  1'b1, 32'h4000, 32'h0, 1'b0, 3'b010, 32'h0, 1'b1, 16, 1'b0};
        vt[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h4004, 32'h0, 2, 32'hCAFEF00D,
                  1'b1, 32'h4004, 32'h0, 1'b0, 3'b010, 32'hCAFEF00D, 1'b0, 2, 1'b0};
        vt[5] = '{1'b1, 32'h200, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 16, 32'h0BADC0DE,
                  1'b0, 32'h200, 32'h0, 1'b0, 3'b010, 32'h0BADC0DE, 1'b0, 16, 1'b0};
        vt[6] = '{1'b1, 32'h300, 1'b0, 1'b1, 3'b111, 32'h9999, 32'hFFFFFFFF, 0, 32'h0,
                  1'b0, 32'h300, 32'h0, 1'b0, 3'b010, 32'h0, 1'b1, 16, 1'b0};

        // ---- reset state ----
        #1;
        chk("reset_outputs", {mem_req, mem_we, mem_size, mem_addr, mem_wdata, i_ack, d_ack,
                              i_rdata, d_rdata, err, cpu_stall}, 0);
        tick(); tick();
        @(negedge CLK);
        Reset = 1'b1;
        tick();
        chk("idle_after_reset", {mem_req, i_ack, d_ack, err, cpu_stall}, 0);

        // ---- table-driven single accesses ----
        for (int v = 0; v < 7; v++) begin
            int k, hi, unstable;
            logic        c_we;
            logic [2:0]  c_size;
            logic [31:0] c_addr, c_wdata;
            i_req = vt[v].i_req; i_addr = vt[v].i_addr;
            d_req = vt[v].d_req; d_we = vt[v].d_we; d_size = vt[v].d_size;
            d_addr = vt[v].d_addr; d_wdata = vt[v].d_wdata;
            mem_ack = 1'b0;
            k = 0;
            while (!mem_req && k < 10) begin tick(); k++; end
            chk($sformatf("v%0d_grant_latency", v), k, 1);
            chk($sformatf("v%0d_mem_addr", v), mem_addr, vt[v].e_addr);
            chk($sformatf("v%0d_mem_we", v), mem_we, vt[v].e_we);
            chk($sformatf("v%0d_mem_size", v), mem_size, vt[v].e_size);
            chk($sformatf("v%0d_mem_wdata", v), mem_wdata, vt[v].e_wdata);
            c_we = mem_we; c_size = mem_size; c_addr = mem_addr; c_wdata = mem_wdata;
            hi = 0; unstable = 0;
            while (mem_req && hi < 40) begin
                hi++;
                if ({mem_we, mem_size, mem_addr, mem_wdata} !== {c_we, c_size, c_addr, c_wdata})
                    unstable++;
                mem_ack   = (hi == vt[v].lat);
                mem_rdata = (hi == vt[v].lat) ? vt[v].rd : $urandom;
                tick();
            end
            mem_ack = 1'b0;
            chk($sformatf("v%0d_unstable_cycles", v), unstable, 0);
            chk($sformatf("v%0d_mem_req_cycles", v), hi, vt[v].e_cyc);
            chk($sformatf("v%0d_i_ack", v), i_ack, !vt[v].e_port);
            chk($sformatf("v%0d_d_ack", v), d_ack, vt[v].e_port);
            chk($sformatf("v%0d_rdata", v), vt[v].e_port ? d_rdata : i_rdata, vt[v].e_rdata);
            chk($sformatf("v%0d_err", v), err, vt[v].e_err);
            chk($sformatf("v%0d_stall_in_ack", v), cpu_stall, vt[v].e_stall);
            i_req = 1'b0; d_req = 1'b0;
            tick();
        end

        // ---- store/fetch collision through to the fetch ack ----
        i_req = 1'b1; i_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b1; d_size = 3'b010; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        #1 chk("col_stall_idle", cpu_stall, 1);
        tick();
        chk("col_first_is_store", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 32'h2000, 32'hDEADBEEF});
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("col_d_ack", {d_ack, i_ack}, 2'b10);
        chk("col_stall_while_i_pending", cpu_stall, 1);
        d_req = 1'b0;
        tick();
        chk("col_stall_idle2", cpu_stall, 1);
        tick();
        chk("col_fetch_grant", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h1000});
        mem_rdata = 32'h00A00113; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("col_i_ack", {i_ack, i_rdata}, {1'b1, 32'h00A00113});
        chk("col_stall_low_on_i_ack", cpu_stall, 0);
        i_req = 1'b0;
        tick();

        // ---- starvation bound: both held continuously ----
        begin
            logic [9:0] seen;
            logic [9:0] exp_pat;
            exp_pat = 10'b0111101111;  // bit g = 1 means grant g goes to D
            seen = '0;
            i_req = 1'b1; i_addr = 32'h500;
            d_req = 1'b1; d_we = 1'b0; d_size = 3'b010; d_addr = 32'h600;
            for (int g = 0; g < 10; g++) begin
                int k;
                k = 0;
                while (!mem_req && k < 5) begin tick(); k++; end
                seen[g] = (mem_addr == 32'h600);
                mem_ack = 1'b1;
                tick();
                mem_ack = 1'b0;
            end
            chk("starve_grant_pattern", seen, exp_pat);
            i_req = 1'b0; d_req = 1'b0;
            tick(); tick();
        end

        // ---- reset pulled in the middle of a D access ----
        begin
            int k, stale;
            i_req = 1'b1; i_addr = 32'h700;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
            tick();
            chk("rst_mid_in_mem_d", {mem_req, mem_addr}, {1'b1, 32'h800});
            #2 Reset = 1'b0;
            #1 chk("rst_mid_outputs_zero", {mem_req, mem_we, mem_size, mem_addr, mem_wdata, i_ack,
                                           d_ack, i_rdata, d_rdata, err}, 0);
            d_req = 1'b0;
            @(negedge CLK);
            Reset = 1'b1;
            k = 0; stale = 0;
            tick();
            while (!mem_req && k < 4) begin
                if (d_ack) stale++;
                tick(); k++;
            end
            chk("rst_fetch_granted", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h700});
            mem_ack = 1'b1; mem_rdata = 32'h13;
            tick();
            mem_ack = 1'b0;
            if (d_ack) stale++;
            chk("rst_no_stale_d_ack", stale, 0);
            chk("rst_i_ack", {i_ack, d_ack, i_rdata}, {1'b1, 1'b0, 32'h13});
            i_req = 1'b0;
            tick();
        end

        // ---- randomized run against the timeline model ----
        Reset = 1'b0;
        tick();
        @(negedge CLK);
        Reset = 1'b1;
        tick();
        m_busy = 0; m_run = 0; m_t = 0; m_n = 0; m_lat = 0; m_rd = '0;
        m_port = 0; m_err = 0; m_we = 0; m_size = '0; m_addr = '0; m_wdata = '0;
        for (int c = 0; c < 3000; c++) begin
            bit in_acc, e_iack, e_dack, dwin;
            // memory side for the current cycle
            in_acc = m_busy && (m_t <= m_n);
            mem_rdata = $urandom;
            if (in_acc) mem_ack = (m_t == m_lat);
            else        mem_ack = ($urandom_range(0, 3) == 0);
            if (in_acc && m_t == m_lat) m_rd = (m_port && m_we) ? 32'h0 : mem_rdata;
            e_iack = m_busy && (m_t == m_n + 1) && !m_port;
            e_dack = m_busy && (m_t == m_n + 1) && m_port;
            #1 chk("rnd_cpu_stall", cpu_stall, (i_req && !e_iack) || (d_req && !e_dack));
            tick();
            // model: advance the current access timeline or arbitrate
            if (m_busy) begin
                if (m_t == m_n + 1) m_busy = 0;
                else                m_t++;
            end else begin
                dwin = d_req && (!i_req || m_run < MAXR);
                if (dwin || i_req) begin
                    int r;
                    m_busy = 1; m_t = 1; m_port = dwin;
                    if (dwin) begin
                        m_we = d_we; m_size = d_size; m_addr = d_addr; m_wdata = d_wdata;
                        m_run = i_req ? ((m_run < 15) ? m_run + 1 : 15) : 0;
                    end else begin
                        m_we = 1'b0; m_size = 3'b010; m_addr = i_addr; m_wdata = 32'h0;
                        m_run = 0;
                    end
                    r = $urandom_range(0, 9);
                    m_lat = (r < 6) ? $urandom_range(1, 3) : (r < 9) ? $urandom_range(4, 16)
                                                                     : $urandom_range(17, 30);
                    m_err = (m_lat > TMO);
                    m_n   = m_err ? TMO : m_lat;
                end
            end
            // compare against the model
            in_acc = m_busy && (m_t <= m_n);
            e_iack = m_busy && (m_t == m_n + 1) && !m_port;
            e_dack = m_busy && (m_t == m_n + 1) && m_port;
            chk("rnd_mem_req", mem_req, in_acc);
            if (in_acc)
                chk("rnd_mem_cmd", {mem_we, mem_size, mem_addr, mem_wdata}, {m_we, m_size, m_addr, m_wdata});
            chk("rnd_acks", {i_ack, d_ack}, {e_iack, e_dack});
            chk("rnd_err", err, (e_iack || e_dack) && m_err);
            if (e_iack) chk("rnd_i_rdata", i_rdata, m_err ? 32'h0 : m_rd);
            if (e_dack) chk("rnd_d_rdata", d_rdata, m_err ? 32'h0 : m_rd);
            // requesters: hold until acked, then drop or issue a fresh request
            if (!i_req) begin
                if ($urandom_range(0, 2) == 0) begin i_req = 1'b1; i_addr = $urandom; end
            end else if (e_iack) begin
                if ($urandom_range(0, 1) == 1) i_addr = $urandom;
                else                           i_req = 1'b0;
            end
            if (!d_req || e_dack) begin
                if ((!d_req && $urandom_range(0, 2) == 0) || (d_req && $urandom_range(0, 1) == 1)) begin
                    d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_size = 3'($urandom_range(0, 7));
                    d_addr = $urandom; d_wdata = $urandom;
                end else begin
                    d_req = 1'b0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between two CPU requesters: the fetch port (I) and the load/store port (D).
- Sits between the pipelined CPU's Instr_Addr and MEM_* outputs and the memory.
- Drives a stall to the CPU while either port has an outstanding request.
- Arbitration is data-priority with a bounded anti-starvation run for fetch; every memory access has a cycle-count timeout.

Parameters:
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width.
- MAX_DATA_RUN, 4, consecutive D grants allowed while I is pending before I is forced a grant; range 1..15.
- TIMEOUT, 255, max cycles mem_req may stay high without mem_ack before abort; range 1..255.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request, held until i_ack.
- i_addr  in  ADDR_W  fetch address, stable while i_req.
- i_ack  out  1  one-cycle fetch completion pulse.
- i_rdata  out  DATA_W  fetch data, valid with i_ack.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  3  transfer type (MEM_type encoding), passed through.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  DATA_W  load data, valid with d_ack.
- err  out  1  one-cycle pulse with i_ack/d_ack when the access timed out.
- cpu_stall  out  1  stall to the CPU pipeline.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_size  out  3  transfer type.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle.

Behaviour:
- Reset (Reset low, async):
  - state = IDLE; run_cnt = 0; tmo_cnt = 0.
  - All outputs 0: mem_req, mem_we, mem_size, mem_addr, mem_wdata, i_ack, d_ack, i_rdata, d_rdata, err, cpu_stall.
- Outputs: all are registered except cpu_stall.
- States: IDLE, MEM_I, MEM_D, RESP.
- IDLE arbitration (sampled each edge):
  - d_req & (~i_req | run_cnt < MAX_DATA_RUN) -> MEM_D.
  - Else i_req -> MEM_I.
  - Else stay in IDLE.
- Run counter:
  - A D grant while i_req=1 increments run_cnt (saturating at 15).
  - Any I grant clears it. A D grant with i_req=0 also clears it.
- On the grant edge:
  - Latch addr/we/size/wdata into the mem_* registers and set mem_req=1. A fetch grant forces mem_we=0, mem_size=3'b010, mem_wdata=0.
  - Clear tmo_cnt.
- MEM_I / MEM_D:
  - mem_req held high and mem_* held stable.
  - tmo_cnt increments each cycle mem_ack=0.
  - mem_ack=1: capture mem_rdata into i_rdata or d_rdata (stores capture 0), assert the matching ack next cycle, drop mem_req, go to RESP.
  - tmo_cnt == TIMEOUT-1 with no mem_ack: abort. Drop mem_req, rdata = 0, assert ack and err together, go to RESP.
  - mem_ack arriving on the timeout cycle counts as success; err = 0.
- RESP:
  - Exactly one cycle; i_ack or d_ack is high; then return to IDLE.
  - Requesters sample ack and must drop or replace req before the next IDLE sample. The arbiter never re-grants the port being acked within RESP.
- Latency:
  - req at cycle 0 -> mem_req at cycle 1.
  - Zero-wait mem_ack in cycle 1 -> ack in cycle 2.
  - Earliest next grant at cycle 3.
  - Throughput: 1 access per 3 cycles at zero wait state.
- cpu_stall (combinational): (i_req & ~i_ack) | (d_req & ~d_ack). It is low in the ack cycle so the pipeline advances exactly once.
- mem_ack while in IDLE or RESP is ignored.
- Request changes while granted are ignored; latched values are used.
- Simultaneous i_req & d_req with run_cnt < MAX_DATA_RUN: D wins.
- Reset asserted mid-access: immediate return to IDLE. No ack is issued and mem_req drops asynchronously.

Test Plan:
1. Lone fetch: i_req with i_addr=0x100; memory acks 1 cycle after mem_req with 0x00500093 -> mem_req cycle 1, mem_addr=0x100, mem_we=0; i_ack and i_rdata=0x00500093 in cycle 2; cpu_stall low in cycle 2.
2. Store vs fetch collision: d_req with we=1, size=3'b010, addr=0x2000, wdata=0xDEADBEEF, same cycle as i_req -> D granted first with mem_we=1 and mem_wdata=0xDEADBEEF; fetch granted after d_ack; cpu_stall high until i_ack.
3. Starvation bound: MAX_DATA_RUN=4; i_req held while d_req is reissued continuously -> exactly 4 D grants, then 1 I grant, then run_cnt=0.
4. Wait states: memory delays mem_ack by 7 cycles -> mem_* stable for 8 cycles; d_ack one cycle after mem_ack; err=0.
5. Timeout: TIMEOUT=16; mem_ack never asserted -> mem_req drops after 16 cycles high; d_ack=1, err=1, d_rdata=0 together; next request is served normally.
6. Reset mid-access: Reset pulled low while in MEM_D -> mem_req=0 and all outputs 0 immediately; after release, a pending i_req is granted with no stale d_ack.
